// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback, drives datapath selects and enables, and counts retired instructions.
module multicycle_controller #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           ImmSrc,
    output logic                 RegWrite,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   retire_s;

    // Unsupported funct3 values resolve to not-taken rather than trapping.
    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic l);
        logic t;
        case (f3)
            3'b000:  t = z;
            3'b001:  t = ~z;
            3'b100:  t = l;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE:     next_state_s = S_FETCH;
            S_FETCH: begin
                if (mem_ready) next_state_s = S_DECODE;
                else           next_state_s = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
                    OP_RTYPE:          next_state_s = S_EXECR;
                    OP_ITYPE:          next_state_s = S_EXECI;
                    OP_BRANCH:         next_state_s = S_BRANCH;
                    OP_JAL:            next_state_s = S_JAL;
                    default:           next_state_s = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LOAD) next_state_s = S_MEMREAD;
                else                   next_state_s = S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (mem_ready) next_state_s = S_MEMWB;
                else           next_state_s = S_MEMREAD;
            end
            S_MEMWB:    next_state_s = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) next_state_s = S_FETCH;
                else           next_state_s = S_MEMWRITE;
            end
            S_EXECR:    next_state_s = S_ALUWB;
            S_EXECI:    next_state_s = S_ALUWB;
            S_ALUWB:    next_state_s = S_FETCH;
            S_BRANCH:   next_state_s = S_FETCH;
            S_JAL:      next_state_s = S_ALUWB;
            S_TRAP:     next_state_s = S_TRAP;
            default:    next_state_s = S_IDLE;
        endcase
    end

    // Output decode; everything not driven by a state stays at its idle value
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        RegWrite  = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
        case (state_r)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = branch_taken(funct3, zero, lt);
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_TRAP:     illegal = 1'b1;
            default:    illegal = 1'b0;
        endcase
    end

    // A jal retires in its ALUWB, so only the final step of each instruction counts
    assign retire_s = (state_r == S_MEMWB) || (state_r == S_ALUWB) || (state_r == S_BRANCH) ||
                      ((state_r == S_MEMWRITE) && mem_ready);

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (retire_s) begin
            instret <= instret + INSTRET_W'(1);
        end else begin
            instret <= instret;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: instruction-level stimulus generates the expected per-cycle control word,
// a negedge monitor compares the DUT outputs against it.
module tb_multicycle_controller;

    localparam int IW = 4;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1110011;

    logic clk = 1'b0;
    logic rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic zero, lt, mem_ready;
    logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [IW-1:0] instret;

    multicycle_controller #(.INSTRET_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero), .lt(lt),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef enum int {K_IDLE, K_FETCH, K_DEC, K_MADR, K_MRD, K_MWB, K_MWR,
                      K_EXR, K_EXI, K_AWB, K_BR, K_JAL, K_TRAP} kind_t;

    typedef struct packed {
        logic pcw, adr, memw, irw;
        logic [1:0] res, srca, srcb, aluop, imm;
        logic regw, ill;
        logic [IW-1:0] cnt;
    } ctl_t;

    ctl_t act;
    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
                  ImmSrc, RegWrite, illegal, instret};

    ctl_t  exp_q[$];
    string name_q[$];
    int checks = 0;
    int errors = 0;
    logic [IW-1:0] retired;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic cur_z, cur_l;
    bit rand_ign;

    function automatic logic rb();
        return logic'($urandom_range(1, 0));
    endfunction

    function automatic logic ign();
        return rand_ign ? rb() : 1'b1;
    endfunction

    // Expected control word for one step of an instruction
    function automatic ctl_t model(kind_t k, logic [6:0] op, logic [2:0] f3, logic z, logic l,
                                   logic mr, logic [IW-1:0] cnt);
        ctl_t c;
        c = '0;
        c.cnt = cnt;
        c.imm = (op == SW) ? 2'b01 : (op == BR) ? 2'b10 : (op == JL) ? 2'b11 : 2'b00;
        case (k)
            K_FETCH: begin c.srcb = 2'b10; c.res = 2'b10; c.irw = mr; c.pcw = mr; end
            K_DEC:   begin c.srca = 2'b01; c.srcb = 2'b01; end
            K_MADR:  begin c.srca = 2'b10; c.srcb = 2'b01; end
            K_MRD:   c.adr = 1'b1;
            K_MWB:   begin c.res = 2'b01; c.regw = 1'b1; end
            K_MWR:   begin c.adr = 1'b1; c.memw = 1'b1; end
            K_EXR:   begin c.srca = 2'b10; c.aluop = 2'b10; end
            K_EXI:   begin c.srca = 2'b10; c.srcb = 2'b01; c.aluop = 2'b10; end
            K_AWB:   c.regw = 1'b1;
            K_BR: begin
                c.srca = 2'b10;
                c.aluop = 2'b01;
                c.pcw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : (f3 == 3'b100) ? l : 1'b0;
            end
            K_JAL:   begin c.srca = 2'b01; c.srcb = 2'b10; c.pcw = 1'b1; end
            K_TRAP:  c.ill = 1'b1;
            default: c.ill = 1'b0;
        endcase
        return c;
    endfunction

    task automatic check(string name, ctl_t got, ctl_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // One clock of stimulus: apply inputs after the edge and queue the expected word
    task automatic step(kind_t k, logic mr, logic rst_v);
        @(posedge clk);
        #1;
        rst_n = rst_v;
        opcode = cur_op; funct3 = cur_f3; zero = cur_z; lt = cur_l; mem_ready = mr;
        if (!rst_v) retired = '0;
        exp_q.push_back(model(k, cur_op, cur_f3, cur_z, cur_l, mr, retired));
        name_q.push_back(k.name());
        if (k == K_MWB || k == K_AWB || k == K_BR || (k == K_MWR && mr)) retired = retired + 1'b1;
    endtask

    task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic z, logic l, int fst, int mst);
        cur_op = op; cur_f3 = f3; cur_z = z; cur_l = l;
        repeat (fst) step(K_FETCH, 1'b0, 1'b1);
        step(K_FETCH, 1'b1, 1'b1);
        step(K_DEC, ign(), 1'b1);
        case (op)
            LW: begin
                step(K_MADR, ign(), 1'b1);
                repeat (mst) step(K_MRD, 1'b0, 1'b1);
                step(K_MRD, 1'b1, 1'b1);
                step(K_MWB, ign(), 1'b1);
            end
            SW: begin
                step(K_MADR, ign(), 1'b1);
                repeat (mst) step(K_MWR, 1'b0, 1'b1);
                step(K_MWR, 1'b1, 1'b1);
            end
            RT: begin step(K_EXR, ign(), 1'b1); step(K_AWB, ign(), 1'b1); end
            IT: begin step(K_EXI, ign(), 1'b1); step(K_AWB, ign(), 1'b1); end
            BR: step(K_BR, ign(), 1'b1);
            JL: begin step(K_JAL, ign(), 1'b1); step(K_AWB, ign(), 1'b1); end
            default: repeat (20) step(K_TRAP, ign(), 1'b1);
        endcase
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check(name_q.pop_front(), act, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors %0d)", errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ops [6];
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BR; ops[5] = JL;
        rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0; lt = 1'b0; mem_ready = 1'b0;
        cur_op = 7'd0; cur_f3 = 3'd0; cur_z = 1'b0; cur_l = 1'b0;
        retired = '0;
        rand_ign = 1'b0;

        repeat (3) step(K_IDLE, 1'b0, 1'b0);
        step(K_IDLE, 1'b1, 1'b1);
        run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);
        rand_ign = 1'b1;
        run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 3);
        run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 2);
        run_instr(BR, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr(BR, 3'b001, 1'b1, 1'b0, 0, 0);
        run_instr(BR, 3'b100, 1'b0, 1'b1, 0, 0);
        run_instr(BR, 3'b010, 1'b1, 1'b1, 0, 0);
        run_instr(JL, 3'b000, 1'b0, 1'b0, 1, 0);

        for (int i = 0; i < 48; i++) begin
            run_instr(ops[$urandom_range(5, 0)], 3'($urandom_range(7, 0)), rb(), rb(),
                      int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));
        end

        run_instr(BAD, 3'b000, 1'b0, 1'b0, 0, 0);
        step(K_IDLE, rb(), 1'b0);
        step(K_IDLE, rb(), 1'b1);
        run_instr(IT, 3'b000, 1'b0, 1'b0, 0, 0);

        // Reset mid-store: outputs must fall back to idle values without waiting for a clock
        cur_op = SW; cur_f3 = 3'b010;
        step(K_FETCH, 1'b1, 1'b1);
        step(K_DEC, rb(), 1'b1);
        step(K_MADR, rb(), 1'b1);
        step(K_MWR, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        retired = '0;
        check("async_reset_memwrite", act, model(K_IDLE, SW, 3'b010, cur_z, cur_l, 1'b0, '0));
        step(K_IDLE, 1'b0, 1'b0);
        step(K_IDLE, 1'b1, 1'b1);
        run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
